cfa_window_ctrl: RTL

Raster-scan sequencer for the CFA demosaic front end. Accepts one raw Bayer pixel per cycle over a valid/ready handshake and drives the enable and data inputs of the `buffer_nx2D` 3x3 window buffer. Tracks the image row and column so it can flag when the buffer's 36-bit window is fully populated and free of row-wrap contamination. Tags each valid window with the Bayer colour of its centre pixel for the downstream interpolator.

---
 rtl/cfa_window_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/cfa_window_ctrl.sv
// rtl/cfa_window_ctrl.sv - raster sequencer feeding buffer_nx2D, flags legal 3x3 windows
module cfa_window_ctrl #(
    parameter int         IMG_W = 5,
    parameter int         IMG_H = 4,
    parameter int         PIX_W = 4,
    parameter logic [1:0] BAYER = 2'b00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_in,
    output logic                     pix_ready,
    output logic                     buf_en,
    output logic [PIX_W-1:0]         buf_din,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] ctr_row,
    output logic [$clog2(IMG_W)-1:0] ctr_col,
    output logic [1:0]               bayer_phase,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] row_m1;
    logic [CW-1:0] col_m1;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          legal;

    assign accept   = pix_valid & pix_ready;
    assign buf_en   = accept;
    assign buf_din  = pix_in;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // Columns 0/1 hold pixels from the previous row's tail, so the window straddles the wrap.
    assign legal    = (row >= RW'(2)) && (col >= CW'(2));
    assign row_m1   = row - RW'(1);
    assign col_m1   = col - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (accept && last_col && last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = (state == STREAM);
        busy       = (state == STREAM);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            win_valid   <= 1'b0;
            ctr_row     <= '0;
            ctr_col     <= '0;
            bayer_phase <= 2'b00;
        end else begin
            win_valid <= accept && legal;
            if (accept && legal) begin
                ctr_row     <= row_m1;
                ctr_col     <= col_m1;
                bayer_phase <= BAYER ^ {row_m1[0], col_m1[0]};
            end
            if (state == IDLE) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                // The final accept clears row instead of stepping past IMG_H-1.
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule
